// File: rtl/frame_tx_sequencer.sv
// Streams one captured frame from the pixel RAM into the UART Tx, one byte per handshake.
// Optional build macro FRAME_TX_HEADER_EN prepends the 0xAA, 0x55 sync header to every frame.
module frame_tx_sequencer #(
    parameter int BYTES_PER_FRAME = 9216,
    parameter int ADDR_W          = 15,
    parameter int TX_TIMEOUT      = 20000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Enable,
    input  logic              i_VS,
    output logic              o_Rd_En,
    output logic [ADDR_W-1:0] o_Rd_Addr,
    input  logic [7:0]        i_Rd_Data,
    output logic              o_Tx_Start,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Done,
    output logic              o_Busy,
    output logic              o_Frame_Ind,
    output logic              o_Overrun,
    output logic              o_Error
);

    localparam int CNT_W = $clog2(BYTES_PER_FRAME + 1);
    localparam int WD_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef FRAME_TX_HEADER_EN
    localparam logic [2:0] S_HDR   = 3'd6;
`endif

    logic [2:0]       state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [WD_W-1:0]  wdog;
    logic             vs_meta_p0;
    logic             vs_s;
    logic             vs_s_d;
    logic             vs_rise;
    logic             in_frame;
`ifdef FRAME_TX_HEADER_EN
    logic [1:0]       hdr_sel;
`endif

    // VSYNC crosses in from the camera domain
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            vs_meta_p0 <= 1'b0;
            vs_s       <= 1'b0;
            vs_s_d     <= 1'b0;
        end else begin
            vs_meta_p0 <= i_VS;
            vs_s       <= vs_meta_p0;
            vs_s_d     <= vs_s;
        end
    end

    assign vs_rise   = vs_s & ~vs_s_d;
    assign in_frame  = (state != S_IDLE) && (state != S_DONE);
    assign count_nxt = count + CNT_W'(1);

    assign o_Rd_En    = (state == S_FETCH);
    assign o_Rd_Addr  = ADDR_W'(count);
    assign o_Tx_Start = (state == S_START);
    assign o_Busy     = (state != S_IDLE);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            wdog        <= '0;
            o_Tx_Byte   <= 8'h00;
            o_Frame_Ind <= 1'b0;
            o_Overrun   <= 1'b0;
            o_Error     <= 1'b0;
`ifdef FRAME_TX_HEADER_EN
            hdr_sel     <= 2'd0;
`endif
        end else begin
            // A new VS edge cannot preempt the frame in flight; it is flagged and dropped
            o_Overrun <= vs_rise & in_frame;

            case (state)
                S_IDLE: begin
                    if (vs_rise && i_Enable) begin
                        count   <= '0;
                        o_Error <= 1'b0;
`ifdef FRAME_TX_HEADER_EN
                        hdr_sel <= 2'd0;
                        state   <= S_HDR;
`else
                        state   <= S_FETCH;
`endif
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    o_Tx_Byte <= i_Rd_Data;
                    state     <= S_START;
                end
`ifdef FRAME_TX_HEADER_EN
                S_HDR: begin
                    o_Tx_Byte <= hdr_sel[0] ? 8'h55 : 8'hAA;
                    state     <= S_START;
                end
`endif
                S_START: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done is checked first so a late done on the last watchdog cycle still counts
                    if (i_Tx_Done) begin
`ifdef FRAME_TX_HEADER_EN
                        if (hdr_sel != 2'd2) begin
                            hdr_sel <= hdr_sel + 2'd1;
                            state   <= (hdr_sel == 2'd0) ? S_HDR : S_FETCH;
                        end else
`endif
                        begin
                            count <= count_nxt;
                            if (count_nxt == CNT_W'(BYTES_PER_FRAME)) begin
                                o_Frame_Ind <= ~o_Frame_Ind;
                                state       <= S_DONE;
                            end else begin
                                state <= S_FETCH;
                            end
                        end
                    end else if (wdog == WD_W'(TX_TIMEOUT - 1)) begin
                        o_Error <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                S_DONE: begin
                    if (!vs_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// Directed bench for frame_tx_sequencer: 4-byte frames, a 10-cycle UART model and a 1-cycle RAM.
// Expected byte stream includes the sync header when FRAME_TX_HEADER_EN is defined.
module tb_frame_tx_sequencer;

    localparam int BPF     = 4;
    localparam int ADDR_W  = 15;
    localparam int TIMEOUT = 50;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              vs;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic              busy;
    logic              frame_ind;
    logic              overrun;
    logic              error;

    frame_tx_sequencer #(
        .BYTES_PER_FRAME(BPF),
        .ADDR_W         (ADDR_W),
        .TX_TIMEOUT     (TIMEOUT)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Enable   (enable),
        .i_VS       (vs),
        .o_Rd_En    (rd_en),
        .o_Rd_Addr  (rd_addr),
        .i_Rd_Data  (rd_data),
        .o_Tx_Start (tx_start),
        .o_Tx_Byte  (tx_byte),
        .i_Tx_Done  (tx_done),
        .o_Busy     (busy),
        .o_Frame_Ind(frame_ind),
        .o_Overrun  (overrun),
        .o_Error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  ram [0:3];
    logic [7:0]  exp_bytes [$];
    logic [7:0]  tx_log [$];
    logic [14:0] rd_log [$];
    int          ovr_cnt = 0;
    int          tx_cnt = 0;
    logic        tx_hang;
    logic        fi_exp;

    // RAM with one cycle of read latency
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= ram[rd_addr[1:0]];
            rd_log.push_back(rd_addr);
        end
    end

    // UART model: done pulse 10 cycles after start unless hung
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt  <= 0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_start) begin
                tx_log.push_back(tx_byte);
                if (!tx_hang) tx_cnt <= 10;
            end else if (tx_cnt != 0) begin
                tx_cnt <= tx_cnt - 1;
                if (tx_cnt == 1) tx_done <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame_ind(input string tag, input logic v);
        int n = 0;
        while (frame_ind !== v && n < 600) begin
            @(negedge clk);
            n++;
        end
        check(tag, frame_ind, v);
    endtask

    task automatic check_stream(input string tag, input int base_tx, input int base_rd);
        logic [31:0] obs;
        check({tag, "_ntx"}, tx_log.size() - base_tx, exp_bytes.size());
        check({tag, "_nrd"}, rd_log.size() - base_rd, BPF);
        for (int i = 0; i < exp_bytes.size(); i++) begin
            obs = (base_tx + i < tx_log.size()) ? 32'(tx_log[base_tx + i]) : 32'hFFFF_FFFF;
            check({tag, "_byte"}, obs, 32'(exp_bytes[i]));
        end
        for (int i = 0; i < BPF; i++) begin
            obs = (base_rd + i < rd_log.size()) ? 32'(rd_log[base_rd + i]) : 32'hFFFF_FFFF;
            check({tag, "_addr"}, obs, i);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_rden"}, rd_en, 1'b0);
        check({tag, "_addr"}, rd_addr, 0);
        check({tag, "_start"}, tx_start, 1'b0);
        check({tag, "_byte"}, tx_byte, 8'h00);
        check({tag, "_find"}, frame_ind, 1'b0);
        check({tag, "_ovr"}, overrun, 1'b0);
        check({tag, "_err"}, error, 1'b0);
    endtask

    initial begin
        int b_tx;
        int b_rd;
        int b_ovr;
        int n;

        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
`ifdef FRAME_TX_HEADER_EN
        exp_bytes.push_back(8'hAA);
        exp_bytes.push_back(8'h55);
`endif
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        exp_bytes.push_back(8'h33);
        exp_bytes.push_back(8'h44);

        rst_n = 1'b0; enable = 1'b1; vs = 1'b0; tx_hang = 1'b0; fi_exp = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Test 1: one normal frame, busy held until VS falls
        b_tx = tx_log.size(); b_rd = rd_log.size();
        vs = 1'b1;
        fi_exp = ~fi_exp;
        wait_frame_ind("t1_find", fi_exp);
        repeat (5) @(negedge clk);
        check_stream("t1", b_tx, b_rd);
        check("t1_busy_vs_high", busy, 1'b1);
        vs = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_busy_vs_low", busy, 1'b0);

        // Test 2: VS re-rises during the second byte
        b_tx = tx_log.size(); b_rd = rd_log.size(); b_ovr = ovr_cnt;
        vs = 1'b1;
        n = 0;
        while (tx_log.size() < b_tx + 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t2_second_byte", tx_log.size() - b_tx, 2);
        vs = 1'b0;
        repeat (4) @(negedge clk);
        vs = 1'b1;
        fi_exp = ~fi_exp;
        wait_frame_ind("t2_find", fi_exp);
        repeat (30) @(negedge clk);
        check_stream("t2", b_tx, b_rd);
        check("t2_overruns", ovr_cnt - b_ovr, 1);
        check("t2_busy_held", busy, 1'b1);
        vs = 1'b0;
        repeat (5) @(negedge clk);
        check("t2_busy_vs_low", busy, 1'b0);

        // Test 3: Tx never completes; abort is seen TIMEOUT+1 cycles after the start cycle
        tx_hang = 1'b1;
        b_tx = tx_log.size();
        vs = 1'b1;
        n = 0;
        while (!tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t3_start_seen", tx_start, 1'b1);
        n = 0;
        while (!error && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t3_err_latency", n, TIMEOUT + 1);
        check("t3_err", error, 1'b1);
        check("t3_find_kept", frame_ind, fi_exp);
        check("t3_one_start", tx_log.size() - b_tx, 1);
        repeat (5) @(negedge clk);
        check("t3_err_sticky", error, 1'b1);
        tx_hang = 1'b0;
        vs = 1'b0;
        repeat (5) @(negedge clk);
        b_tx = tx_log.size(); b_rd = rd_log.size();
        vs = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_rearm_busy", busy, 1'b1);
        check("t3_rearm_err_clr", error, 1'b0);
        fi_exp = ~fi_exp;
        wait_frame_ind("t3_find", fi_exp);
        repeat (2) @(negedge clk);
        check_stream("t3", b_tx, b_rd);
        vs = 1'b0;
        repeat (5) @(negedge clk);

        // Test 4: asynchronous reset while waiting on the second byte
        b_tx = tx_log.size();
        vs = 1'b1;
        n = 0;
        while (tx_log.size() < b_tx + 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        vs = 1'b0;
        #1;
        check_idle_outputs("t4_async");
        @(negedge clk);
        rst_n = 1'b1;
        fi_exp = 1'b0;
        b_tx = tx_log.size(); b_rd = rd_log.size();
        repeat (20) @(negedge clk);
        check("t4_idle_busy", busy, 1'b0);
        check("t4_idle_nord", rd_log.size() - b_rd, 0);
        vs = 1'b1;
        fi_exp = ~fi_exp;
        wait_frame_ind("t4_find", fi_exp);
        repeat (2) @(negedge clk);
        check_stream("t4", b_tx, b_rd);
        vs = 1'b0;
        repeat (5) @(negedge clk);

        // Test 5: arming blocked while disabled, then a normal frame
        enable = 1'b0;
        b_tx = tx_log.size(); b_rd = rd_log.size();
        vs = 1'b1;
        repeat (30) @(negedge clk);
        check("t5_dis_busy", busy, 1'b0);
        check("t5_dis_nord", rd_log.size() - b_rd, 0);
        check("t5_dis_notx", tx_log.size() - b_tx, 0);
        vs = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        vs = 1'b1;
        fi_exp = ~fi_exp;
        wait_frame_ind("t5_find", fi_exp);
        repeat (2) @(negedge clk);
        check_stream("t5", b_tx, b_rd);
        vs = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_busy_end", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
